// File: rtl/div_16bit_arbiter.sv
// Round-robin arbiter sharing one iterative 16/8 restoring divider among NREQ requesters.
// One quotient bit per cycle, MSB first; result returned on a valid/ready response port.
module div_16bit_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*16-1:0]   i_req_a,
    input  logic [NREQ*8-1:0]    i_req_b,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [15:0]          o_rsp_quot,
    output logic [15:0]          o_rsp_rem,
    output logic                 o_rsp_div_zero
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [IDW-1:0]   r_last;
    logic [IDW-1:0]   r_id;
    logic [15:0]      r_a;
    logic [7:0]       r_b;
    logic [15:0]      r_quot;
    logic [7:0]       r_rem;
    logic [4:0]       r_cnt;

    logic             w_grant_any;
    logic [IDW-1:0]   w_grant_id;
    logic [IDW-1:0]   w_idx;
    logic [NREQ-1:0]  w_grant_oh;
    logic [15:0]      w_a_sel;
    logic [7:0]       w_b_sel;
    logic [8:0]       w_rem_sh;
    logic             w_ge;
    logic [7:0]       w_rem_nx;
    logic [15:0]      w_quot_nx;

    // Round-robin search starting one past the last grant
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = IDW'((32'(r_last) + k + 32'd1) % NREQ);
            if (!w_grant_any && i_req_valid[w_idx]) begin
                w_grant_any = 1'b1;
                w_grant_id  = w_idx;
            end
        end
    end

    assign w_grant_oh  = w_grant_any ? (NREQ'(1) << w_grant_id) : '0;
    assign o_req_ready = (r_state == S_IDLE && !i_rst) ? w_grant_oh : '0;
    assign w_a_sel     = i_req_a[16*w_grant_id +: 16];
    assign w_b_sel     = i_req_b[8*w_grant_id +: 8];

    // Restoring step; the partial remainder stays below B, so 8 bits hold it
    assign w_rem_sh  = {r_rem, r_a[15]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_nx  = 8'(w_ge ? (w_rem_sh - {1'b0, r_b}) : w_rem_sh);
    assign w_quot_nx = {r_quot[14:0], w_ge};

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_any) w_state_nx = (w_b_sel == 8'd0) ? S_DONE : S_BUSY;
            S_BUSY:  if (r_cnt == 5'd1) w_state_nx = S_DONE;
            S_DONE:  if (i_rsp_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last         <= IDW'(NREQ - 1);
            r_id           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_quot         <= '0;
            r_rem          <= '0;
            r_cnt          <= '0;
            o_rsp_valid    <= 1'b0;
            o_rsp_id       <= '0;
            o_rsp_quot     <= '0;
            o_rsp_rem      <= '0;
            o_rsp_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_a    <= w_a_sel;
                        r_b    <= w_b_sel;
                        r_id   <= w_grant_id;
                        r_last <= w_grant_id;
                        r_quot <= '0;
                        r_rem  <= '0;
                        r_cnt  <= 5'd16;
                        if (w_b_sel == 8'd0) begin
                            o_rsp_valid    <= 1'b1;
                            o_rsp_id       <= w_grant_id;
                            o_rsp_quot     <= 16'hFFFF;
                            o_rsp_rem      <= '0;
                            o_rsp_div_zero <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    r_a    <= {r_a[14:0], 1'b0};
                    r_rem  <= w_rem_nx;
                    r_quot <= w_quot_nx;
                    r_cnt  <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        o_rsp_valid    <= 1'b1;
                        o_rsp_id       <= r_id;
                        o_rsp_quot     <= w_quot_nx;
                        o_rsp_rem      <= {8'h00, w_rem_nx};
                        o_rsp_div_zero <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (i_rsp_ready) o_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_16bit_arbiter.sv
// Self-checking bench for div_16bit_arbiter: vector table, directed corner sequences
// and randomized transactions checked against a plain-arithmetic divide model.
module tb_div_16bit_arbiter;

    localparam int unsigned NREQ = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [15:0]       rsp_quot;
    logic [15:0]       rsp_rem;
    logic              rsp_div_zero;

    int n_checks = 0;
    int n_errors = 0;

    div_16bit_arbiter #(.NREQ(NREQ)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_a        (req_a),
        .i_req_b        (req_b),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_id       (rsp_id),
        .o_rsp_quot     (rsp_quot),
        .o_rsp_rem      (rsp_rem),
        .o_rsp_div_zero (rsp_div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz);
        if (b == 8'd0) begin
            q = 16'hFFFF; r = 16'd0; dz = 1'b1;
        end else begin
            q  = 16'(int'(a) / int'(b));
            r  = 16'(int'(a) % int'(b));
            dz = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Issue one request on a single requester and check the full response
    task automatic run_one(input string tag, input int id, input logic [15:0] a,
                           input logic [7:0] b, input logic [15:0] eq,
                           input logic [15:0] er, input logic edz, input int stall);
        int n;
        int lat;
        rsp_ready = (stall == 0);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[16*id +: 16] = a;
        req_b[8*id +: 8]   = b;
        #1;
        n = 0;
        while (!req_ready[id] && n < 100) begin tick(); n++; end
        chk({tag, " ready"}, 32'(req_ready), 32'(1 << id));
        tick();
        req_valid = '0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin tick(); lat++; end
        chk({tag, " latency"}, 32'(lat), (b == 8'd0) ? 32'd1 : 32'd17);
        chk({tag, " id"}, 32'(rsp_id), 32'(id));
        chk({tag, " quot"}, 32'(rsp_quot), 32'(eq));
        chk({tag, " rem"}, 32'(rsp_rem), 32'(er));
        chk({tag, " dz"}, 32'(rsp_div_zero), 32'(edz));
        if (stall > 0) begin
            repeat (stall) tick();
            chk({tag, " hold"}, {15'd0, rsp_valid, rsp_quot}, {15'd0, 1'b1, eq});
            rsp_ready = 1'b1;
        end
        tick();
        chk({tag, " drop"}, 32'(rsp_valid), 32'd0);
    endtask

    vec_t        tbl[7];
    logic [15:0] ta[NREQ];
    logic [7:0]  tb[NREQ];
    logic [15:0] mq, mr;
    logic        mdz;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int lat;
        logic seen;
        rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (3) tick();
        chk("reset ready", 32'(req_ready), 32'd0);
        chk("reset rsp", {12'd0, rsp_valid, rsp_div_zero, rsp_id, rsp_quot}, 32'd0);
        chk("reset rem", 32'(rsp_rem), 32'd0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        tbl[0] = '{0, 16'd1000,  8'd7,   16'd142,   16'd6, 1'b0};
        tbl[1] = '{1, 16'hFFFF,  8'd1,   16'hFFFF,  16'd0, 1'b0};
        tbl[2] = '{2, 16'd5,     8'd200, 16'd0,     16'd5, 1'b0};
        tbl[3] = '{3, 16'h1234,  8'd0,   16'hFFFF,  16'd0, 1'b1};
        tbl[4] = '{0, 16'hFFFF,  8'd255, 16'd257,   16'd0, 1'b0};
        tbl[5] = '{1, 16'd0,     8'd9,   16'd0,     16'd0, 1'b0};
        tbl[6] = '{2, 16'd65000, 8'd3,   16'd21666, 16'd2, 1'b0};
        for (int i = 0; i < 7; i++)
            run_one($sformatf("vec%0d", i), tbl[i].id, tbl[i].a, tbl[i].b,
                    tbl[i].q, tbl[i].r, tbl[i].dz, 0);

        // All requesters pending from reset: grants rotate 0,1,2,3,0
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ta[i] = 16'($urandom);
            tb[i] = 8'($urandom_range(1, 255));
            req_a[16*i +: 16] = ta[i];
            req_b[8*i +: 8]   = tb[i];
        end
        rsp_ready = 1'b1;
        req_valid = '1;
        #1;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (req_ready == '0 && n < 100) begin tick(); n++; end
            chk($sformatf("rr grant%0d", g), 32'(req_ready), 32'(1 << (g % NREQ)));
            tick();
            lat = 1;
            while (!rsp_valid && lat < 100) begin tick(); lat++; end
            chk($sformatf("rr busy_ready%0d", g), 32'(req_ready), 32'd0);
            chk($sformatf("rr id%0d", g), 32'(rsp_id), 32'(g % NREQ));
            model(ta[g % NREQ], tb[g % NREQ], mq, mr, mdz);
            chk($sformatf("rr quot%0d", g), 32'(rsp_quot), 32'(mq));
            chk($sformatf("rr rem%0d", g), 32'(rsp_rem), 32'(mr));
            chk($sformatf("rr identity%0d", g),
                32'(rsp_quot) * 32'(tb[g % NREQ]) + 32'(rsp_rem), 32'(ta[g % NREQ]));
            tick();
            if (g == 4) req_valid = '0;
        end
        tick();

        // Response back-pressure in DONE with another requester waiting
        rsp_ready = 1'b0;
        req_a[16 +: 16] = 16'd1000; req_b[8 +: 8] = 8'd7;
        req_valid = 4'b0010;
        #1;
        n = 0;
        while (!req_ready[1] && n < 100) begin tick(); n++; end
        tick();
        req_valid = '0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin tick(); lat++; end
        chk("bp latency", 32'(lat), 32'd17);
        req_a[32 +: 16] = 16'd77; req_b[16 +: 8] = 8'd7;
        req_valid = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("bp hold%0d", c),
                {rsp_valid, rsp_div_zero, rsp_id, 4'(req_ready), 8'd0, rsp_quot},
                {1'b1, 1'b0, 2'd1, 4'd0, 8'd0, 16'd142});
            chk($sformatf("bp rem%0d", c), 32'(rsp_rem), 32'd6);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp drop", 32'(rsp_valid), 32'd0);
        chk("bp next grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin tick(); lat++; end
        chk("bp next quot", {16'(lat), rsp_quot}, {16'd17, 16'd11});
        tick();

        // Reset mid-divide aborts it and re-arms the pointer at requester 0
        req_a[16 +: 16] = 16'd40000; req_b[8 +: 8] = 8'd13;
        req_valid = 4'b0010;
        #1;
        n = 0;
        while (!req_ready[1] && n < 100) begin tick(); n++; end
        tick();
        req_valid = '0;
        repeat (8) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort rsp", {12'd0, rsp_valid, rsp_div_zero, rsp_id, rsp_quot}, 32'd0);
        chk("abort rem", 32'(rsp_rem), 32'd0);
        chk("abort ready", 32'(req_ready), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin tick(); if (rsp_valid) seen = 1'b1; end
        chk("abort no rsp", 32'(seen), 32'd0);
        req_a[0 +: 16] = 16'd100; req_b[0 +: 8] = 8'd9;
        req_a[48 +: 16] = 16'd100; req_b[24 +: 8] = 8'd9;
        req_valid = 4'b1001;
        #1;
        chk("abort first grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin tick(); lat++; end
        chk("abort after", {16'(rsp_id), rsp_quot}, {16'd0, 16'd11});
        tick();

        // Randomized transactions against the arithmetic model
        for (int t = 0; t < 30; t++) begin
            int id;
            int st;
            logic [15:0] a;
            logic [7:0]  b;
            id = int'($urandom_range(0, NREQ - 1));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            st = int'($urandom_range(0, 3));
            model(a, b, mq, mr, mdz);
            run_one($sformatf("rnd%0d", t), id, a, b, mq, mr, mdz, st);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
